// File: rtl/bpm_link_tx_arbiter.sv
// Round-robin, FA-paced packet arbiter sharing one Aurora AXI-Stream TX link
// between NREQ sources; drains and discards source data while the channel is down.
module bpm_link_tx_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                       auroraUserClk,
    input  logic                       auroraReset,
    input  logic                       auroraFAstrobe,
    input  logic                       auroraChannelUp,
    input  logic [NREQ*DATA_WIDTH-1:0] s_tdata,
    input  logic [NREQ-1:0]            s_tvalid,
    input  logic [NREQ-1:0]            s_tlast,
    output logic [NREQ-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]      BPM_TEST_AXI_STREAM_TX_tdata,
    output logic                       BPM_TEST_AXI_STREAM_TX_tvalid,
    output logic                       BPM_TEST_AXI_STREAM_TX_tlast,
    input  logic                       BPM_TEST_AXI_STREAM_TX_tready,
    output logic [NREQ-1:0]            grant,
    output logic                       faOverrun,
    output logic [15:0]                packetCount
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] armed_q, armed_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [15:0]     packet_count_q, packet_count_d;
    logic            fa_overrun_q, fa_overrun_d;

    logic [IW-1:0]   gidx_c;
    logic            send_c;
    logic            done_c;
    logic [NREQ-1:0] req_c;
    logic [NREQ-1:0] clr_c;

    // One-hot grant register to index of the granted source.
    always_comb begin
        gidx_c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_q[i]) gidx_c = IW'(i);
        end
    end

    assign send_c = (state_q == SEND) && auroraChannelUp;
    assign done_c = send_c && s_tvalid[gidx_c] && BPM_TEST_AXI_STREAM_TX_tready
                    && s_tlast[gidx_c];
    assign req_c  = s_tvalid & armed_q;

    // Zero-latency pass-through of the granted source; forced idle when not sending.
    always_comb begin
        BPM_TEST_AXI_STREAM_TX_tdata  = '0;
        BPM_TEST_AXI_STREAM_TX_tvalid = 1'b0;
        BPM_TEST_AXI_STREAM_TX_tlast  = 1'b0;
        s_tready                      = '0;
        if (send_c) begin
            BPM_TEST_AXI_STREAM_TX_tdata  = s_tdata[gidx_c*DATA_WIDTH +: DATA_WIDTH];
            BPM_TEST_AXI_STREAM_TX_tvalid = s_tvalid[gidx_c];
            BPM_TEST_AXI_STREAM_TX_tlast  = s_tlast[gidx_c];
        end
        if (!auroraChannelUp) begin
            s_tready = '1;
        end else if (state_q == SEND) begin
            s_tready[gidx_c] = BPM_TEST_AXI_STREAM_TX_tready;
        end
    end

    // Next-state, arbitration and bookkeeping.
    always_comb begin
        logic found;
        int   idx;
        state_d        = state_q;
        grant_d        = grant_q;
        armed_d        = armed_q;
        last_grant_d   = last_grant_q;
        packet_count_d = packet_count_q;
        clr_c          = '0;
        found          = 1'b0;
        idx            = 0;

        if (!auroraChannelUp) begin
            state_d = IDLE;
            grant_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    for (int k = 1; k <= int'(NREQ); k++) begin
                        idx = (int'(last_grant_q) + k) % int'(NREQ);
                        if (!found && req_c[IW'(idx)]) begin
                            found                = 1'b1;
                            grant_d              = '0;
                            grant_d[IW'(idx)]    = 1'b1;
                            state_d              = SEND;
                        end
                    end
                end
                SEND: begin
                    if (done_c) begin
                        clr_c[gidx_c]  = 1'b1;
                        last_grant_d   = gidx_c;
                        packet_count_d = packet_count_q + 16'd1;
                        grant_d        = '0;
                        state_d        = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A strobe re-arms everything, overriding a same-cycle tlast clear.
        if (!auroraChannelUp) begin
            armed_d = '0;
        end else if (auroraFAstrobe) begin
            armed_d = '1;
        end else begin
            armed_d = armed_q & ~clr_c;
        end

        fa_overrun_d = auroraFAstrobe && (|(armed_q & ~clr_c));
    end

    always_ff @(posedge auroraUserClk or posedge auroraReset) begin
        if (auroraReset) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            armed_q        <= '0;
            last_grant_q   <= IW'(NREQ - 1);
            packet_count_q <= '0;
            fa_overrun_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            armed_q        <= armed_d;
            last_grant_q   <= last_grant_d;
            packet_count_q <= packet_count_d;
            fa_overrun_q   <= fa_overrun_d;
        end
    end

    assign grant       = grant_q;
    assign faOverrun   = fa_overrun_q;
    assign packetCount = packet_count_q;

endmodule

// File: tb/tb_bpm_link_tx_arbiter.sv
// Directed bench for bpm_link_tx_arbiter: per-cycle vector table plus
// hand-written sequences for overrun, strobe/tlast collision, channel drop and reset.
module tb_bpm_link_tx_arbiter;

    logic         clk;
    logic         rst;
    logic         stb;
    logic         up;
    logic [127:0] s_tdata;
    logic [3:0]   s_tvalid;
    logic [3:0]   s_tlast;
    logic [3:0]   s_tready;
    logic [31:0]  tx_tdata;
    logic         tx_tvalid;
    logic         tx_tlast;
    logic         tx_tready;
    logic [3:0]   grant;
    logic         ovr;
    logic [15:0]  pcnt;

    int errors = 0;
    int checks = 0;
    int tick   = 0;

    bpm_link_tx_arbiter #(.NREQ(4), .DATA_WIDTH(32)) dut (
        .auroraUserClk                 (clk),
        .auroraReset                   (rst),
        .auroraFAstrobe                (stb),
        .auroraChannelUp               (up),
        .s_tdata                       (s_tdata),
        .s_tvalid                      (s_tvalid),
        .s_tlast                       (s_tlast),
        .s_tready                      (s_tready),
        .BPM_TEST_AXI_STREAM_TX_tdata  (tx_tdata),
        .BPM_TEST_AXI_STREAM_TX_tvalid (tx_tvalid),
        .BPM_TEST_AXI_STREAM_TX_tlast  (tx_tlast),
        .BPM_TEST_AXI_STREAM_TX_tready (tx_tready),
        .grant                         (grant),
        .faOverrun                     (ovr),
        .packetCount                   (pcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stb, up;
        logic [3:0]  vld, lst;
        logic        rdy;
        logic [3:0]  e_gnt;
        logic        e_tv, e_tl;
        logic [3:0]  e_srdy;
        logic [15:0] e_cnt;
        logic        e_ovr;
    } vec_t;

    function automatic vec_t mk(input int r, s, u, v, l, rd, g, tv, tl, sr, c, o);
        vec_t t;
        t.rst = 1'(r);  t.stb = 1'(s);   t.up = 1'(u);
        t.vld = 4'(v);  t.lst = 4'(l);   t.rdy = 1'(rd);
        t.e_gnt = 4'(g); t.e_tv = 1'(tv); t.e_tl = 1'(tl);
        t.e_srdy = 4'(sr); t.e_cnt = 16'(c); t.e_ovr = 1'(o);
        return t;
    endfunction

    function automatic logic [31:0] pat(input int src, input int t);
        return {8'hA5, 8'(src), 16'(t)};
    endfunction

    task automatic set_data(input int t);
        for (int i = 0; i < 4; i++) s_tdata[i*32 +: 32] = pat(i, t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int s, u, v, l, r);
        @(negedge clk);
        stb = 1'(s); up = 1'(u); s_tvalid = 4'(v); s_tlast = 4'(l); tx_tready = 1'(r);
        tick++;
        set_data(tick);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stb = 1'b0; up = 1'b1; s_tvalid = '0; s_tlast = '0;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[$];
    vec_t v;
    logic [31:0] e_td;
    int pulses;

    initial begin
        rst = 1'b1; stb = 1'b0; up = 1'b1; s_tvalid = '0; s_tlast = '0;
        tx_tready = 1'b0; s_tdata = '0;

        //           rst stb up vld lst rdy  gnt tv tl srdy cnt ovr
        // single source, 4-beat packet
        vecs.push_back(mk(1, 0, 1,  0, 0, 0,   0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1,  0, 0, 0,   0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 1,  0, 0, 1,   0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1,  1, 0, 1,   0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1,  1, 0, 1,   1, 1, 0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1,  1, 0, 1,   1, 1, 0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1,  1, 0, 1,   1, 1, 0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1,  1, 1, 1,   1, 1, 1,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1,  1, 0, 1,   0, 0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 1,  1, 0, 1,   0, 0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 1,  1, 0, 1,   0, 0, 0,  0, 1, 0));
        // round robin over all four sources with stalling tready
        vecs.push_back(mk(1, 0, 1,  0, 0, 0,   0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 15, 0, 0,   0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 15, 0, 0,   0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 15, 0, 0,   1, 1, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 15, 0, 1,   1, 1, 0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 15, 1, 0,   1, 1, 1,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 15, 1, 1,   1, 1, 1,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 15, 0, 1,   0, 0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 15, 2, 1,   2, 1, 1,  2, 1, 0));
        vecs.push_back(mk(0, 0, 1, 15, 0, 1,   0, 0, 0,  0, 2, 0));
        vecs.push_back(mk(0, 0, 1, 15, 0, 1,   4, 1, 0,  4, 2, 0));
        vecs.push_back(mk(0, 0, 1, 15, 4, 1,   4, 1, 1,  4, 2, 0));
        vecs.push_back(mk(0, 0, 1, 15, 0, 1,   0, 0, 0,  0, 3, 0));
        vecs.push_back(mk(0, 0, 1, 15, 8, 0,   8, 1, 1,  0, 3, 0));
        vecs.push_back(mk(0, 0, 1, 15, 8, 1,   8, 1, 1,  8, 3, 0));
        vecs.push_back(mk(0, 0, 1, 15, 0, 1,   0, 0, 0,  0, 4, 0));
        vecs.push_back(mk(0, 0, 1, 15, 0, 1,   0, 0, 0,  0, 4, 0));

        foreach (vecs[i]) begin
            v = vecs[i];
            @(negedge clk);
            rst = v.rst; stb = v.stb; up = v.up;
            s_tvalid = v.vld; s_tlast = v.lst; tx_tready = v.rdy;
            tick = i;
            set_data(i);
            #1;
            e_td = '0;
            for (int j = 0; j < 4; j++) if (v.e_gnt[j] && v.up) e_td = pat(j, i);
            chk($sformatf("row%0d grant", i),    32'(grant),     32'(v.e_gnt));
            chk($sformatf("row%0d tvalid", i),   32'(tx_tvalid), 32'(v.e_tv));
            chk($sformatf("row%0d tlast", i),    32'(tx_tlast),  32'(v.e_tl));
            chk($sformatf("row%0d tdata", i),    tx_tdata,       e_td);
            chk($sformatf("row%0d s_tready", i), 32'(s_tready),  32'(v.e_srdy));
            chk($sformatf("row%0d count", i),    32'(pcnt),      32'(v.e_cnt));
            chk($sformatf("row%0d overrun", i),  32'(ovr),       32'(v.e_ovr));
        end

        // overrun: second strobe 200 cycles after the first with nothing sent
        drive(1, 1, 0, 0, 1);
        pulses = 0;
        repeat (199) begin
            drive(0, 1, 0, 0, 1);
            if (ovr) pulses++;
        end
        chk("ovr_quiet_window", 32'(pulses), 32'd0);
        drive(1, 1, 0, 0, 1);
        chk("ovr_at_strobe", 32'(ovr), 32'd0);
        drive(0, 1, 0, 0, 1);
        chk("ovr_pulse", 32'(ovr), 32'd1);
        drive(0, 1, 0, 0, 1);
        chk("ovr_single", 32'(ovr), 32'd0);

        // strobe coincident with source 1's tlast accept
        do_reset();
        drive(1, 1, 13, 15, 1);
        repeat (6) drive(0, 1, 13, 15, 1);
        drive(0, 1, 2, 2, 1);
        chk("coin_count3", 32'(pcnt), 32'd3);
        drive(1, 1, 2, 2, 1);
        chk("coin_grant1", 32'(grant), 32'd2);
        chk("coin_tlast", 32'(tx_tlast), 32'd1);
        drive(0, 1, 2, 2, 1);
        chk("coin_no_ovr", 32'(ovr), 32'd0);
        chk("coin_count4", 32'(pcnt), 32'd4);
        drive(0, 1, 2, 2, 1);
        chk("coin_rearmed", 32'(grant), 32'd2);

        // channel drop at beat 2 of 5
        do_reset();
        drive(1, 1, 1, 0, 1);
        drive(0, 1, 1, 0, 1);
        drive(0, 1, 1, 0, 1);
        chk("drop_beat1_tvalid", 32'(tx_tvalid), 32'd1);
        drive(0, 0, 1, 0, 1);
        chk("drop_tvalid", 32'(tx_tvalid), 32'd0);
        chk("drop_sready", 32'(s_tready), 32'hF);
        drive(0, 0, 1, 0, 1);
        chk("drop_grant", 32'(grant), 32'd0);
        chk("drop_sready2", 32'(s_tready), 32'hF);
        chk("drop_count", 32'(pcnt), 32'd0);
        drive(0, 1, 1, 0, 1);
        drive(0, 1, 1, 0, 1);
        chk("drop_disarmed", 32'(grant), 32'd0);
        drive(1, 1, 1, 0, 1);
        drive(0, 1, 1, 0, 1);
        for (int b = 0; b < 5; b++) begin
            drive(0, 1, 1, (b == 4) ? 1 : 0, 1);
            chk($sformatf("fresh_beat%0d_tvalid", b), 32'(tx_tvalid), 32'd1);
            chk($sformatf("fresh_beat%0d_tdata", b), tx_tdata, pat(0, tick));
        end
        drive(0, 1, 1, 0, 1);
        chk("fresh_count", 32'(pcnt), 32'd1);

        // asynchronous reset mid-packet
        do_reset();
        drive(1, 1, 15, 1, 1);
        drive(0, 1, 15, 1, 1);
        drive(0, 1, 15, 1, 1);
        chk("rst_pre_grant0", 32'(grant), 32'd1);
        drive(0, 1, 15, 0, 1);
        chk("rst_pre_count", 32'(pcnt), 32'd1);
        drive(0, 1, 15, 0, 1);
        chk("rst_pre_grant1", 32'(grant), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tvalid", 32'(tx_tvalid), 32'd0);
        chk("rst_tlast", 32'(tx_tlast), 32'd0);
        chk("rst_tdata", tx_tdata, 32'd0);
        chk("rst_sready", 32'(s_tready), 32'd0);
        chk("rst_count", 32'(pcnt), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 15, 0, 1);
        drive(0, 1, 15, 0, 1);
        drive(0, 1, 15, 0, 1);
        chk("rst_first_grant", 32'(grant), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
